pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Sequencing controller for the 5-stage IF/ID/EX/MEM/WB core pipeline.
//  - Runs the instruction-fetch handshake FSM.
//  - Owns per-stage valid bits and the pipeline-register load enables.
//  - Resolves load-use and data-bus stalls, and squashes on EX redirects.
//  - Keeps cycle, stall and retire counters for the difftest and perf reporting.
// PARAMETERS
//  CNT_W  64  width of the cycle_cnt, stall_cnt and instret_cnt counters
// PORTS
//  clk          in   1      core clock
//  reset        in   1      synchronous, active-high
//  ireq_valid   out  1      fetch request to ibus; held until iresp_ok
//  iresp_ok     in   1      ibus data_ok; raw instruction is valid this cycle
//  id_rs1       in   5      ID source register 1
//  id_rs2       in   5      ID source register 2
//  id_use_rs1   in   1      ID instruction reads rs1
//  id_use_rs2   in   1      ID instruction reads rs2
//  ex_dst       in   5      EX destination register (creg_addr_t)
//  ex_regwrite  in   1      EX instruction writes a register (ctl.regwrite)
//  ex_is_load   in   1      EX instruction is a load
//  ex_redirect  in   1      EX resolved a taken branch/jump; held while EX is frozen
//  dmem_busy    in   1      MEM-stage dbus access still outstanding
//  pc_en        out  1      PC <= PC+4
//  pc_redirect  out  1      PC <= redirect target (has priority over pc_en)
//  ifbuf_load   out  1      latch the arriving instruction into the IF hold buffer
//  ifid_en      out  1      IF/ID register load enable
//  idex_en      out  1      ID/EX register load enable
//  exmem_en     out  1      EX/MEM register load enable
//  v_id         out  1      ID stage holds a valid instruction
//  v_ex         out  1      EX stage holds a valid instruction
//  v_mem        out  1      MEM stage holds a valid instruction
//  v_wb         out  1      WB stage holds a valid instruction
//  cycle_cnt    out  CNT_W  cycles since reset
//  stall_cnt    out  CNT_W  cycles with mem_stall or load_use asserted
//  instret_cnt  out  CNT_W  retired instructions
// BEHAVIOUR
//  Reset: FSM=F_IDLE; all v_* = 0; all counters = 0; every enable output = 0.
//  Internal terms (all combinational):
//   mem_stall = v_mem & dmem_busy
//   load_use  = v_ex & ex_is_load & ex_regwrite & (ex_dst != 0) & v_id
//               & ((id_use_rs1 & id_rs1 == ex_dst) | (id_use_rs2 & id_rs2 == ex_dst))
//   redir     = v_ex & ex_redirect & ~mem_stall
//   freeze_id = mem_stall | load_use
//   deliver   = (F_WAIT & iresp_ok) | F_HOLD
//   accept    = deliver & ~freeze_id & ~redir
//  Output equations:
//   pc_en = accept; pc_redirect = redir
//   ifid_en = accept; ifbuf_load = F_WAIT & iresp_ok & ~accept & ~redir
//   idex_en = ~mem_stall; exmem_en = ~mem_stall
//   ireq_valid = 1 in F_WAIT and F_DROP, 0 otherwise
//  Next valid bits:
//   v_id  <= redir ? 0 : freeze_id ? v_id : accept
//   v_ex  <= mem_stall ? v_ex : (v_id & ~load_use & ~redir); load_use inserts an EX bubble
//   v_mem <= mem_stall ? v_mem : v_ex
//   v_wb  <= v_mem & ~mem_stall; MEM/WB register loads every cycle
//  Fetch FSM:
//   F_IDLE -> F_WAIT unconditionally. One dead cycle so a new PC settles.
//   F_WAIT: redir & ~iresp_ok -> F_DROP; redir & iresp_ok -> F_IDLE (response discarded);
//           accept -> F_WAIT (next request, ireq_valid stays high);
//           iresp_ok & ~accept -> F_HOLD; otherwise stay.
//   F_HOLD: redir -> F_IDLE; accept -> F_WAIT; otherwise stay.
//   F_DROP: iresp_ok -> F_IDLE (response discarded, never reaches ID).
//           A further redir in F_DROP stays F_DROP; pc_redirect still asserts.
//  Priority: reset > mem_stall > redir > load_use.
//   mem_stall freezes every stage up to MEM; WB receives a bubble.
//  Latency: instruction arriving in F_WAIT with no stall is valid in ID the next cycle.
//  Counters: increment by 1 per cycle (instret on v_wb); wrap modulo 2^CNT_W.
//  Reset asserted mid-operation: next cycle equals the reset state. An outstanding
//   ibus response after reset is the ibus master's concern, not this block's.
// TESTING
//  1 Reset 3 cycles, then iresp_ok every cycle with no hazards
//    -> F_IDLE 1 cycle, ireq_valid=1 from cycle 1, v_wb first =1 at cycle 5, instret increments each cycle after.
//  2 v_ex=1, load with ex_dst=5; ID reads id_rs1=5, id_use_rs1=1
//    -> ifid_en=0 and pc_en=0 for 1 cycle, v_ex<=0 bubble, stall_cnt+1. Repeat with ex_dst=0 -> no stall.
//  3 v_mem=1, dmem_busy=1 for 4 cycles while iresp_ok=1
//    -> ifbuf_load=1 once, FSM in F_HOLD, v_wb=0 for 4 cycles, stall_cnt+4, then resumes with no instruction lost.
//  4 ex_redirect=1 in F_WAIT, iresp_ok arriving 2 cycles later
//    -> pc_redirect=1, v_id=0, F_DROP, arriving response not loaded, F_IDLE, then F_WAIT.
//  5 ex_redirect and dmem_busy both asserted for 2 cycles
//    -> pc_redirect=0 while stalled; asserts on the first cycle dmem_busy=0; v_id squashed then.
//  6 Preload cycle_cnt to 2^CNT_W-1 via force, advance 1 clock -> cycle_cnt=0. Reset mid-F_DROP -> F_IDLE, all v_*=0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Sequencing controller for the 5-stage IF/ID/EX/MEM/WB pipeline: fetch handshake,
// per-stage valid bits, stall/squash resolution and perf counters.
module pipe_ctrl #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    output logic             ireq_valid,
    input  logic             iresp_ok,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_dst,
    input  logic             ex_regwrite,
    input  logic             ex_is_load,
    input  logic             ex_redirect,
    input  logic             dmem_busy,
    output logic             pc_en,
    output logic             pc_redirect,
    output logic             ifbuf_load,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             v_id,
    output logic             v_ex,
    output logic             v_mem,
    output logic             v_wb,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    typedef enum logic [1:0] {
        F_IDLE,
        F_WAIT,
        F_HOLD,
        F_DROP
    } fetch_state_t;

    fetch_state_t state;
    fetch_state_t state_nx;

    logic mem_stall;
    logic load_use;
    logic redir;
    logic freeze_id;
    logic resp_in_wait;
    logic deliver;
    logic accept;

    always_comb begin
        mem_stall    = v_mem & dmem_busy;
        load_use     = v_ex & ex_is_load & ex_regwrite & (ex_dst != 5'd0) & v_id
                       & ((id_use_rs1 & (id_rs1 == ex_dst)) | (id_use_rs2 & (id_rs2 == ex_dst)));
        redir        = v_ex & ex_redirect & ~mem_stall;
        freeze_id    = mem_stall | load_use;
        resp_in_wait = (state == F_WAIT) & iresp_ok;
        deliver      = resp_in_wait | (state == F_HOLD);
        accept       = deliver & ~freeze_id & ~redir;
    end

    // Enables are forced low while reset is held so nothing upstream moves.
    always_comb begin
        pc_en       = accept & ~reset;
        pc_redirect = redir & ~reset;
        ifid_en     = accept & ~reset;
        ifbuf_load  = resp_in_wait & ~accept & ~redir & ~reset;
        idex_en     = ~mem_stall & ~reset;
        exmem_en    = ~mem_stall & ~reset;
    end

    always_comb begin
        state_nx = state;
        case (state)
            F_IDLE: state_nx = F_WAIT;
            F_WAIT: begin
                if (redir)
                    state_nx = iresp_ok ? F_IDLE : F_DROP;
                else if (accept)
                    state_nx = F_WAIT;
                else if (iresp_ok)
                    state_nx = F_HOLD;
            end
            F_HOLD: begin
                if (redir)
                    state_nx = F_IDLE;
                else if (accept)
                    state_nx = F_WAIT;
            end
            F_DROP: begin
                if (iresp_ok)
                    state_nx = F_IDLE;
            end
            default: state_nx = F_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= F_IDLE;
            ireq_valid <= 1'b0;
        end else begin
            state      <= state_nx;
            ireq_valid <= (state_nx == F_WAIT) || (state_nx == F_DROP);
        end
    end

    // A load-use stall holds ID and drops a bubble into EX; a MEM stall freezes
    // everything up to MEM and lets WB drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            v_id  <= 1'b0;
            v_ex  <= 1'b0;
            v_mem <= 1'b0;
            v_wb  <= 1'b0;
        end else begin
            if (redir)
                v_id <= 1'b0;
            else if (!freeze_id)
                v_id <= accept;
            if (!mem_stall) begin
                v_ex  <= v_id & ~load_use & ~redir;
                v_mem <= v_ex;
            end
            v_wb <= v_mem & ~mem_stall;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt   <= '0;
            stall_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt   <= cycle_cnt + CNT_W'(1);
            stall_cnt   <= stall_cnt + CNT_W'(freeze_id);
            instret_cnt <= instret_cnt + CNT_W'(v_wb);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed and randomized checks of pipe_ctrl against a flag-based fetch/pipeline
// reference model; counters use a narrow width so wrap-around is reachable.
module tb_pipe_ctrl;

    localparam int CNT_W = 8;
    localparam int CMASK = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ireq_valid, iresp_ok;
    logic [4:0] id_rs1, id_rs2, ex_dst;
    logic id_use_rs1, id_use_rs2, ex_regwrite, ex_is_load, ex_redirect, dmem_busy;
    logic pc_en, pc_redirect, ifbuf_load, ifid_en, idex_en, exmem_en;
    logic v_id, v_ex, v_mem, v_wb;
    logic [CNT_W-1:0] cycle_cnt, stall_cnt, instret_cnt;

    pipe_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .ireq_valid(ireq_valid), .iresp_ok(iresp_ok),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_dst(ex_dst), .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load),
        .ex_redirect(ex_redirect), .dmem_busy(dmem_busy), .pc_en(pc_en),
        .pc_redirect(pc_redirect), .ifbuf_load(ifbuf_load), .ifid_en(ifid_en),
        .idex_en(idex_en), .exmem_en(exmem_en), .v_id(v_id), .v_ex(v_ex), .v_mem(v_mem),
        .v_wb(v_wb), .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit       rst;
        bit       resp;
        bit       busy;
        bit       redirect;
        bit       is_load;
        bit       regwrite;
        bit       use1;
        bit       use2;
        bit [4:0] rs1;
        bit [4:0] rs2;
        bit [4:0] dst;
    } stim_t;

    int total = 0;
    int bad = 0;

    // Fetch side: exactly one of dead-cycle / request-pending / holding / dropping.
    bit m_dead, m_pend, m_hold, m_drop;
    bit n_dead, n_pend, n_hold, n_drop;
    bit pv[4];
    bit npv[4];
    int m_cyc, m_stl, m_ret, n_cyc, n_stl, n_ret;
    bit state_known = 1'b0;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        bit mstall, luse, rd, arrive, have, take, hit1, hit2;
        mstall = pv[2] && dmem_busy;
        hit1 = id_use_rs1 && (id_rs1 == ex_dst);
        hit2 = id_use_rs2 && (id_rs2 == ex_dst);
        luse = pv[1] && pv[0] && ex_is_load && ex_regwrite && (ex_dst != 0) && (hit1 || hit2);
        rd = pv[1] && ex_redirect && !mstall;
        arrive = m_pend && iresp_ok;
        have = arrive || m_hold;
        take = have && !mstall && !luse && !rd;

        checkVal("pc_en", pc_en, !reset && take);
        checkVal("pc_redirect", pc_redirect, !reset && rd);
        checkVal("ifid_en", ifid_en, !reset && take);
        checkVal("ifbuf_load", ifbuf_load, !reset && arrive && !take && !rd);
        checkVal("idex_en", idex_en, !reset && !mstall);
        checkVal("exmem_en", exmem_en, !reset && !mstall);
        if (state_known) begin
            checkVal("ireq_valid", ireq_valid, m_pend || m_drop);
            checkVal("v_id", v_id, pv[0]);
            checkVal("v_ex", v_ex, pv[1]);
            checkVal("v_mem", v_mem, pv[2]);
            checkVal("v_wb", v_wb, pv[3]);
            checkVal("cycle_cnt", cycle_cnt, m_cyc);
            checkVal("stall_cnt", stall_cnt, m_stl);
            checkVal("instret_cnt", instret_cnt, m_ret);
        end

        if (reset) begin
            {n_dead, n_pend, n_hold, n_drop} = 4'b1000;
            npv = '{0, 0, 0, 0};
            n_cyc = 0; n_stl = 0; n_ret = 0;
        end else begin
            {n_dead, n_pend, n_hold, n_drop} = {m_dead, m_pend, m_hold, m_drop};
            if (m_dead) {n_dead, n_pend} = 2'b01;
            else if (m_pend && rd) {n_pend, n_dead, n_drop} = {1'b0, iresp_ok, !iresp_ok};
            else if (m_pend && !take && iresp_ok) {n_pend, n_hold} = 2'b01;
            else if (m_hold && rd) {n_hold, n_dead} = 2'b01;
            else if (m_hold && take) {n_hold, n_pend} = 2'b01;
            else if (m_drop && iresp_ok) {n_drop, n_dead} = 2'b01;

            npv[3] = pv[2] && !mstall;
            npv[2] = mstall ? pv[2] : pv[1];
            npv[1] = mstall ? pv[1] : (pv[0] && !luse && !rd);
            npv[0] = rd ? 1'b0 : ((mstall || luse) ? pv[0] : take);
            n_cyc = (m_cyc + 1) & CMASK;
            n_stl = (m_stl + int'(mstall || luse)) & CMASK;
            n_ret = (m_ret + int'(pv[3])) & CMASK;
        end
    endtask

    task automatic applyStimulus(input stim_t st);
        reset = st.rst;
        iresp_ok = st.resp;
        dmem_busy = st.busy;
        ex_redirect = st.redirect;
        ex_is_load = st.is_load;
        ex_regwrite = st.regwrite;
        id_use_rs1 = st.use1;
        id_use_rs2 = st.use2;
        id_rs1 = st.rs1;
        id_rs2 = st.rs2;
        ex_dst = st.dst;
        #1;
        checkOutput();
    endtask

    task automatic clockStep();
        @(posedge clk);
        {m_dead, m_pend, m_hold, m_drop} = {n_dead, n_pend, n_hold, n_drop};
        pv = npv;
        m_cyc = n_cyc; m_stl = n_stl; m_ret = n_ret;
        if (reset) state_known = 1'b1;
        @(negedge clk);
    endtask

    task automatic step(input stim_t st);
        applyStimulus(st);
        clockStep();
    endtask

    stim_t s;
    int stall0;
    int ibuf_pulses;
    bit reached;

    initial begin
        {reset, iresp_ok, dmem_busy, ex_redirect, ex_is_load, ex_regwrite} = 6'b100000;
        {id_use_rs1, id_use_rs2, id_rs1, id_rs2, ex_dst} = '0;
        @(negedge clk);

        // Reset held three cycles, then fetch streams with no hazards.
        s = '0; s.rst = 1'b1;
        for (int i = 0; i < 3; i++) step(s);
        s = '0; s.resp = 1'b1;
        for (int k = 0; k < 9; k++) begin
            applyStimulus(s);
            checkVal("t1_ireq", ireq_valid, k >= 1);
            checkVal("t1_vwb", v_wb, k >= 5);
            checkVal("t1_instret", instret_cnt, (k > 5) ? k - 5 : 0);
            checkVal("t1_cycle", cycle_cnt, k);
            clockStep();
        end

        // Load-use hazard on rs1, then the same pattern against x0.
        stall0 = m_stl;
        s.is_load = 1'b1; s.regwrite = 1'b1; s.dst = 5'd5; s.rs1 = 5'd5; s.use1 = 1'b1;
        applyStimulus(s);
        checkVal("t2_ifid", ifid_en, 0);
        checkVal("t2_pcen", pc_en, 0);
        clockStep();
        s = '0; s.resp = 1'b1;
        applyStimulus(s);
        checkVal("t2_bubble", v_ex, 0);
        checkVal("t2_stall", stall_cnt, stall0 + 1);
        clockStep();
        s.is_load = 1'b1; s.regwrite = 1'b1; s.dst = 5'd0; s.rs1 = 5'd0; s.use1 = 1'b1;
        applyStimulus(s);
        checkVal("t2_x0_pcen", pc_en, 1);
        checkVal("t2_x0_ifid", ifid_en, 1);
        clockStep();

        // Data-bus stall for four cycles while instructions keep arriving.
        s = '0; s.resp = 1'b1;
        for (int i = 0; i < 4; i++) step(s);
        stall0 = m_stl;
        ibuf_pulses = 0;
        s.busy = 1'b1;
        for (int j = 0; j < 4; j++) begin
            applyStimulus(s);
            if (ifbuf_load) ibuf_pulses++;
            if (j >= 1) begin
                checkVal("t3_vwb", v_wb, 0);
                checkVal("t3_hold_ireq", ireq_valid, 0);
            end
            clockStep();
        end
        s.busy = 1'b0;
        applyStimulus(s);
        checkVal("t3_ibuf_pulses", ibuf_pulses, 1);
        checkVal("t3_stall", stall_cnt, stall0 + 4);
        checkVal("t3_vwb_after", v_wb, 0);
        checkVal("t3_resume", pc_en, 1);
        clockStep();

        // Redirect while waiting; the late response must be discarded.
        for (int i = 0; i < 4; i++) step(s);
        s = '0;
        step(s);
        s.redirect = 1'b1;
        applyStimulus(s);
        checkVal("t4_redirect", pc_redirect, 1);
        clockStep();
        s = '0;
        applyStimulus(s);
        checkVal("t4_drop_ireq", ireq_valid, 1);
        checkVal("t4_vid", v_id, 0);
        clockStep();
        s.resp = 1'b1;
        applyStimulus(s);
        checkVal("t4_drop_ifid", ifid_en, 0);
        checkVal("t4_drop_ibuf", ifbuf_load, 0);
        clockStep();
        s = '0;
        applyStimulus(s);
        checkVal("t4_idle_ireq", ireq_valid, 0);
        clockStep();
        applyStimulus(s);
        checkVal("t4_wait_ireq", ireq_valid, 1);
        clockStep();

        // Redirect held under a data-bus stall waits for the stall to clear.
        s = '0; s.resp = 1'b1;
        for (int i = 0; i < 5; i++) step(s);
        s.redirect = 1'b1; s.busy = 1'b1;
        for (int j = 0; j < 2; j++) begin
            applyStimulus(s);
            checkVal("t5_redir_stalled", pc_redirect, 0);
            clockStep();
        end
        s.busy = 1'b0;
        applyStimulus(s);
        checkVal("t5_redir_released", pc_redirect, 1);
        clockStep();
        s = '0; s.resp = 1'b1;
        applyStimulus(s);
        checkVal("t5_squash", v_id, 0);
        clockStep();

        // Counter wrap, then reset in the middle of a drop.
        reached = 1'b0;
        for (int i = 0; i < 300 && !reached; i++) begin
            if (m_cyc == CMASK) reached = 1'b1;
            else step(s);
        end
        checkVal("t6_reach_max", reached, 1);
        step(s);
        applyStimulus(s);
        checkVal("t6_wrap", cycle_cnt, 0);
        clockStep();
        for (int i = 0; i < 4; i++) step(s);
        s = '0;
        step(s);
        s.redirect = 1'b1;
        step(s);
        s = '0; s.rst = 1'b1;
        applyStimulus(s);
        checkVal("t6_in_drop", ireq_valid, 1);
        clockStep();
        s = '0;
        applyStimulus(s);
        checkVal("t6_rst_valids", {v_id, v_ex, v_mem, v_wb}, 0);
        checkVal("t6_rst_ireq", ireq_valid, 0);
        checkVal("t6_rst_cycle", cycle_cnt, 0);
        clockStep();

        // Randomized traffic with small register numbers so hazards are frequent.
        for (int i = 0; i < 1500; i++) begin
            s = '0;
            s.rst = ($urandom_range(0, 99) == 0);
            s.resp = ($urandom_range(0, 9) < 6);
            s.busy = ($urandom_range(0, 3) == 0);
            s.redirect = ($urandom_range(0, 6) == 0);
            s.is_load = $urandom_range(0, 1);
            s.regwrite = ($urandom_range(0, 3) != 0);
            s.use1 = $urandom_range(0, 1);
            s.use2 = $urandom_range(0, 1);
            s.rs1 = 5'($urandom_range(0, 3));
            s.rs2 = 5'($urandom_range(0, 3));
            s.dst = 5'($urandom_range(0, 3));
            step(s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
